// File: rtl/jtcps1_pkg.sv
// jtcps1_pkg: shared FSM states, slot indices and address widths for the CPS1 gfx fetch
package jtcps1_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MAP, ST_WAIT, ST_DONE} state_t;
  localparam int OBJ     = 0;
  localparam int SCROLL1 = 1;
  localparam int SCROLL2 = 2;
  localparam int SCROLL3 = 3;
  localparam int STAR    = 4;
  localparam int NSLOT   = 5;
  localparam int AW      = 20;
  localparam int CW      = 10;
endpackage

// File: rtl/jtcps1_rr_arb.sv
// jtcps1_rr_arb: round-robin pick of the first requesting slot at or after ptr
module jtcps1_rr_arb
  import jtcps1_pkg::*;
(
  input  logic [NSLOT-1:0] req,
  input  logic [2:0]       ptr,
  output logic [NSLOT-1:0] grant,
  output logic [2:0]       idx
);
  logic [3:0] s;
  logic [2:0] j;
  // scan from farthest to nearest so the nearest requester is written last
  always_comb begin
    grant = '0;
    idx = '0;
    s = '0;
    j = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + 4'(i);
      j = 3'(s >= 4'(NSLOT) ? s - 4'(NSLOT) : s);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/jtcps1_gfx_fetch.sv
// jtcps1_gfx_fetch: arbitrates layer tile fetches through the bank mapper into ROM reads.
// JTCPS1_STARFIELD_EN adds the star field (slot 4) to the arbitration.
module jtcps1_gfx_fetch
  import jtcps1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NSLOT-1:0]    slot_req,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [31:0]         slot_data,
  output logic [2:0]          map_layer,
  output logic [CW-1:0]       map_cin,
  input  logic [CW-1:0]       map_cout,
  output logic [AW-1:0]       rom_addr,
  output logic                rom_cs,
  input  logic                rom_ok,
  input  logic [31:0]         rom_data
);
`ifdef JTCPS1_STARFIELD_EN
  localparam logic [NSLOT-1:0] EN = 5'h1f;
`else
  localparam logic [NSLOT-1:0] EN = 5'h0f;
`endif
  state_t st, st_nx;
  logic [2:0] ptr, sel;
  logic [NSLOT-1:0] gnt;
  logic [AW-CW-1:0] addr_lo;
  jtcps1_rr_arb u_arb (
    .req   (slot_req & EN),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (sel)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= ST_IDLE;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    case (st)
      ST_IDLE: st_nx = |gnt ? ST_MAP : ST_IDLE;
      ST_MAP:  st_nx = ST_WAIT;
      ST_WAIT: st_nx = rom_ok ? ST_DONE : ST_WAIT;
      default: st_nx = ST_IDLE;
    endcase
  end
  // map_layer doubles as the latched grant index for the whole transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= 3'(OBJ);
      addr_lo <= '0;
      map_layer <= '0;
      map_cin <= '0;
      rom_addr <= '0;
      rom_cs <= 1'b0;
      slot_ok <= '0;
      slot_data <= '0;
    end else begin
      slot_ok <= '0;
      if (st == ST_IDLE && |gnt) begin
        map_layer <= sel;
        map_cin <= slot_addr[AW*sel+(AW-CW) +: CW];
        addr_lo <= slot_addr[AW*sel +: AW-CW];
        ptr <= sel == 3'(NSLOT - 1) ? 3'(OBJ) : sel + 3'd1;
      end
      if (st == ST_MAP) begin
        rom_addr <= {map_cout, addr_lo};
        rom_cs <= 1'b1;
      end
      if (st == ST_WAIT && rom_ok) begin
        rom_cs <= 1'b0;
        if (slot_req[map_layer] && EN[map_layer]) begin
          slot_ok[map_layer] <= 1'b1;
          slot_data <= rom_data;
        end
      end
    end
endmodule

// File: tb/tb_jtcps1_gfx_fetch.sv
// tb_jtcps1_gfx_fetch: randomized transaction-level check of jtcps1_gfx_fetch against a reference model
module tb_jtcps1_gfx_fetch;
`ifdef JTCPS1_STARFIELD_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif
  localparam logic [4:0] EN = NS == 5 ? 5'h1f : 5'h0f;
  logic clk = 0, rst = 1;
  logic [4:0] slot_req = '0;
  logic [99:0] slot_addr = '0;
  logic [4:0] slot_ok;
  logic [31:0] slot_data;
  logic [2:0] map_layer;
  logic [9:0] map_cin, map_cout;
  logic [19:0] rom_addr;
  logic rom_cs;
  logic rom_ok = 0;
  logic [31:0] rom_data = '0;
  int checks = 0, failures = 0;
  int ptr = 0;
  logic [31:0] last_data = '0;

  jtcps1_gfx_fetch dut (
    .clk(clk), .rst(rst), .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_data(slot_data), .map_layer(map_layer),
    .map_cin(map_cin), .map_cout(map_cout), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] key(input logic [2:0] l);
    case (l)
      3'd0: return 10'h2E0;
      3'd1: return 10'h155;
      3'd2: return 10'h0F3;
      3'd3: return 10'h3A1;
      default: return 10'h1C7;
    endcase
  endfunction

  assign map_cout = map_cin ^ key(map_layer);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [4:0] r);
    int j;
    for (int i = 0; i < NS; i++) begin
      j = (ptr + i) % NS;
      if (r[j] && EN[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) if (!rst) chk("onehot", 32'($countones(slot_ok) <= 1), 1);

  task automatic run_txn(input logic [4:0] req, input bit drop, input int dly,
                         input bit rnd, input logic [99:0] av, input logic [31:0] dv);
    int s;
    logic [19:0] a;
    logic [31:0] d;
    @(negedge clk);
    slot_req = req;
    if (rnd) for (int i = 0; i < 5; i++) slot_addr[20*i +: 20] = 20'($urandom);
    else slot_addr = av;
    s = pick(req);
    if (s < 0) begin
      chk("no_req", 0, 1);
      return;
    end
    a = slot_addr[20*s +: 20];
    ptr = (s + 1) % NS;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) slot_addr[20*i +: 20] = 20'($urandom);
    rom_ok = 1'($urandom_range(0, 1));
    rom_data = $urandom;
    @(posedge clk);
    #1;
    chk("cs_lat", 32'(rom_cs), 1);
    chk("rom_addr", 32'(rom_addr), 32'({a[19:10] ^ key(3'(s)), a[9:0]}));
    chk("layer", 32'(map_layer), 32'(s));
    chk("cin", 32'(map_cin), 32'(a[19:10]));
    @(negedge clk);
    rom_ok = 0;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("cs_hold", 32'(rom_cs), 1);
    end
    if (drop) slot_req = req & ~(5'b1 << s);
    d = rnd ? $urandom : dv;
    rom_data = d;
    rom_ok = 1;
    if (!drop) last_data = d;
    @(posedge clk);
    #1;
    chk("slot_ok", 32'(slot_ok), drop ? 0 : 32'(1) << s);
    chk("slot_data", slot_data, last_data);
    chk("cs_drop", 32'(rom_cs), 0);
    @(negedge clk);
    rom_ok = 0;
    slot_req = '0;
    rom_data = $urandom;
    @(posedge clk);
    #1;
    chk("ok_pulse", 32'(slot_ok), 0);
  endtask

  initial begin
    logic [4:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ok", 32'(slot_ok), 0);
    chk("rst_data", slot_data, 0);
    chk("rst_cs", 32'(rom_cs), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_layer", 32'(map_layer), 0);
    chk("rst_cin", 32'(map_cin), 0);
    @(negedge clk);
    rst = 0;
    run_txn(5'b00001, 0, 0, 0, {80'h0, 20'h12345}, 32'hDEADBEEF);
    chk("obj_addr_fixed", 32'(rom_addr), 32'hAA345);
    chk("obj_data_fixed", slot_data, 32'hDEADBEEF);
    repeat (6) run_txn(5'h1f, 0, 2, 1, '0, '0);
    run_txn(5'b00100, 1, 1, 1, '0, '0);
    run_txn(5'h1f, 0, 1, 1, '0, '0);
    @(negedge clk);
    slot_req = 5'b00100;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_cs", 32'(rom_cs), 1);
    @(negedge clk);
    rst = 1;
    slot_req = '0;
    #1;
    chk("abort_cs", 32'(rom_cs), 0);
    ptr = 0;
    last_data = '0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rom_ok = 1;
    rom_data = $urandom;
    @(negedge clk);
    rom_ok = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_ok", 32'(slot_ok), 0);
      chk("abort_idle", 32'(rom_cs), 0);
    end
    chk("abort_data", slot_data, 0);
    run_txn(5'h1f, 0, 0, 1, '0, '0);
    repeat (4) run_txn(5'b10001, 0, 1, 1, '0, '0);
    for (int n = 0; n < 150; n++) begin
      r = 5'($urandom);
      while ((r & EN) == 0) r = 5'($urandom);
      run_txn(r, $urandom_range(0, 9) == 0, int'($urandom_range(0, 4)), 1, '0, '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
